reg_access_master: RTL and testbench
====================================

Name: reg_access_master

Overview:
Initiator side of the register-bank access protocol. Accepts single register requests (address, read/write, data) over a valid/ready interface and decodes the address into a one-hot select. Drives each register's sel/rd/data strobe for exactly one cycle, captures the read data, and returns it over a valid/ready response channel. Sits between the host/CPU-side bridge and the register bank of the block.

Parameters:
REG_WIDTH, 32, data width of every register
ADDR_WIDTH, 4, request address width
REG_NUM, 12, number of registers in the bank; legal addresses are 0..REG_NUM-1
POLL_MAX, 8, maximum accesses per poll request (only used with REG_MST_POLL_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  register index
req_wdata  in  REG_WIDTH  write data
rsp_vld  out  1  response valid
rsp_rdy  in  1  response ready
rsp_rdata  out  REG_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  address out of range, or poll timeout
reg_wr_sel  out  REG_NUM  one-hot register select
reg_wr_rd  out  1  1 = write, 0 = read, qualified by reg_wr_sel
reg_wr_data  out  REG_WIDTH  write data to the bank
reg_rd_bus  in  REG_NUM*REG_WIDTH  flattened reg_rd_out of all registers; register i occupies [i*REG_WIDTH +: REG_WIDTH]

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every output is 0, including req_rdy. The state machine returns to IDLE.
- Request and response transfers occur on any cycle where vld and rdy are both 1.
- States: IDLE, ACCESS, RESP, plus POLL_GAP when polling is compiled in. State encoding is binary.
- IDLE:
  - req_rdy = 1.
  - On a request transfer, latch wr, addr and wdata.
  - If addr >= REG_NUM, go to RESP with err=1 and rdata=0. No select is asserted.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - reg_wr_sel = one-hot(addr), reg_wr_rd = wr.
  - reg_wr_data = wdata for a write, 0 for a read.
  - For a read, capture slice addr of reg_rd_bus into the rdata register at the end of the cycle.
  - Then go to RESP.
- RESP:
  - rsp_vld = 1, with rsp_rdata and rsp_err held stable until rsp_rdy=1.
  - Then return to IDLE.
  - req_rdy = 0 in every state except IDLE.
- Latency from request acceptance at cycle T:
  - Legal address: strobe at T+1, rsp_vld at T+2.
  - Illegal address: rsp_vld at T+1.
  - Back-to-back throughput is one request per 3 cycles when rsp_rdy is held at 1.
- reg_wr_sel, reg_wr_rd and reg_wr_data are registered outputs, 0 outside ACCESS.
- Reset mid-operation: select drops immediately and the pending request is discarded. No response is issued after reset release.
- req_vld while not ready is ignored. There is no queueing.
- No request is accepted in the same cycle a response completes; IDLE is always entered first.

Optional Feature:
- REG_MST_POLL_EN defined:
  - Adds input port req_poll (1 bit), latched with the request, and state POLL_GAP.
  - For a read with poll=1: after each ACCESS, if captured bit 0 = 1 and accesses < POLL_MAX, go to POLL_GAP for one cycle (no strobe), then ACCESS again.
  - If bit 0 = 0, go to RESP with err=0.
  - If POLL_MAX accesses are done with bit 0 still 1, go to RESP with err=1 and the last rdata.
  - The access counter is $clog2(POLL_MAX+1) bits and is cleared on acceptance.
  - req_poll is ignored for writes and illegal addresses.
- Not defined: no req_poll port, no POLL_GAP state, no counter.

Decomposition:
- Shared include reg_mst_defines.vh holds the state encodings (IDLE=0, ACCESS=1, RESP=2, POLL_GAP=3) and the request/response field width localparams.
- One sub-module, reg_mst_addr_dec: combinational address-to-one-hot decode, range check (out-of-range flag), and reg_rd_bus slice mux.

Test Plan:
1. Write: addr=2, wdata=0xA5A50001 accepted at T -> at T+1 reg_wr_sel=12'h004, reg_wr_rd=1, reg_wr_data=0xA5A50001 for one cycle; at T+2 rsp_vld=1, rsp_rdata=0, rsp_err=0.
2. Read: addr=5 with slice 5 = 0x00000001 -> at T+1 reg_wr_sel=12'h020, reg_wr_rd=0; at T+2 rsp_rdata=0x00000001, rsp_err=0.
3. Illegal address: addr=13 -> reg_wr_sel stays 0; rsp_vld at T+1 with rsp_err=1, rsp_rdata=0.
4. Backpressure: rsp_rdy=0 for 5 cycles while req_vld=1 with new requests -> rsp_vld and rsp_rdata held stable, req_rdy=0, no new strobe; after rsp_rdy=1 the next request is accepted one cycle later.
5. Reset mid-operation: rst=1 during ACCESS -> reg_wr_sel=0 immediately; after release rsp_vld never rises, and req_rdy=1 on the first clock edge after release.
6. (REG_MST_POLL_EN) Poll read of addr 0:
   - bit 0 = 1 for 3 reads, then 0 -> 4 select pulses each separated by one idle cycle, then rsp_err=0.
   - bit 0 stuck at 1 -> exactly 8 pulses, then rsp_err=1.

Source files
------------

// File: rtl/reg_access_master_pkg.sv
// rtl/reg_access_master_pkg.sv - state encoding and default widths for reg_access_master
// Optional feature macro: REG_MST_POLL_EN (adds the POLL_GAP state and poll bound)
package reg_access_master_pkg;

  localparam int REG_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int REG_NUM_DEF    = 12;
`ifdef REG_MST_POLL_EN
  localparam int POLL_MAX_DEF   = 8;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
`ifdef REG_MST_POLL_EN
    ST_POLL_GAP = 2'd3,
`endif
    ST_RESP     = 2'd2
  } state_t;

endpackage

// File: rtl/reg_access_master_if.sv
// rtl/reg_access_master_if.sv - request/response channels and register-bank bus of reg_access_master
// Optional feature macro: REG_MST_POLL_EN (adds req_poll)
interface reg_access_master_if #(
  parameter int REG_WIDTH  = reg_access_master_pkg::REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = reg_access_master_pkg::ADDR_WIDTH_DEF,
  parameter int REG_NUM    = reg_access_master_pkg::REG_NUM_DEF
);

  logic                         req_vld;
  logic                         req_rdy;
  logic                         req_wr;
  logic [ADDR_WIDTH-1:0]        req_addr;
  logic [REG_WIDTH-1:0]         req_wdata;
`ifdef REG_MST_POLL_EN
  logic                         req_poll;
`endif
  logic                         rsp_vld;
  logic                         rsp_rdy;
  logic [REG_WIDTH-1:0]         rsp_rdata;
  logic                         rsp_err;
  logic [REG_NUM-1:0]           reg_wr_sel;
  logic                         reg_wr_rd;
  logic [REG_WIDTH-1:0]         reg_wr_data;
  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_bus;

  // master = the access initiator; slave = host bridge plus register bank
  modport master (
`ifdef REG_MST_POLL_EN
    input  req_poll,
`endif
    input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy, reg_rd_bus,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err, reg_wr_sel, reg_wr_rd, reg_wr_data
  );

  modport slave (
`ifdef REG_MST_POLL_EN
    output req_poll,
`endif
    output req_vld, req_wr, req_addr, req_wdata, rsp_rdy, reg_rd_bus,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err, reg_wr_sel, reg_wr_rd, reg_wr_data
  );

endinterface

// File: rtl/reg_mst_addr_dec.sv
// rtl/reg_mst_addr_dec.sv - one-hot address decode, range check and read-data slice mux
module reg_mst_addr_dec
  import reg_access_master_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int REG_NUM    = REG_NUM_DEF
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [REG_NUM*REG_WIDTH-1:0] rd_bus,
  output logic [REG_NUM-1:0]           sel,
  output logic                         oor,
  output logic [REG_WIDTH-1:0]         rdata
);

  always_comb begin
    sel   = '0;
    rdata = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        sel[i] = 1'b1;
        rdata  = rd_bus[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // no register matched, so the address lies outside the bank
  assign oor = ~|sel;

endmodule

// File: rtl/reg_access_master.sv
// rtl/reg_access_master.sv - single-request register access initiator with one-cycle strobes
// Optional feature macro: REG_MST_POLL_EN (poll-until-bit0-clear reads)
module reg_access_master
  import reg_access_master_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
`ifdef REG_MST_POLL_EN
  parameter int POLL_MAX   = POLL_MAX_DEF,
`endif
  parameter int REG_NUM    = REG_NUM_DEF
) (
  input logic                 clk,
  input logic                 rst,
  reg_access_master_if.master bus
);

  state_t                  state;
  logic                    rdy_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rsp_vld_q;
  logic                    rsp_err_q;
  logic [REG_WIDTH-1:0]    rdata_q;
  logic [REG_NUM-1:0]      sel_q;
  logic                    wr_rd_q;
  logic [REG_WIDTH-1:0]    wr_data_q;
`ifdef REG_MST_POLL_EN
  localparam int CW = $clog2(POLL_MAX + 1);
  logic                    poll_q;
  logic [CW-1:0]           cnt_q;
`endif

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic [REG_NUM-1:0]      dec_sel;
  logic                    dec_oor;
  logic [REG_WIDTH-1:0]    dec_rdata;
  logic                    req_fire;

  // the incoming address is decoded while idle, the latched one afterwards
  assign dec_addr = (state == ST_IDLE) ? bus.req_addr : addr_q;
  assign req_fire = bus.req_vld & rdy_q;

  reg_mst_addr_dec #(
    .REG_WIDTH  (REG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_NUM    (REG_NUM)
  ) u_addr_dec (
    .addr   (dec_addr),
    .rd_bus (bus.reg_rd_bus),
    .sel    (dec_sel),
    .oor    (dec_oor),
    .rdata  (dec_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rdy_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q   <= '0;
      sel_q     <= '0;
      wr_rd_q   <= 1'b0;
      wr_data_q <= '0;
`ifdef REG_MST_POLL_EN
      poll_q    <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      sel_q     <= '0;
      wr_rd_q   <= 1'b0;
      wr_data_q <= '0;
      case (state)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (req_fire) begin
            rdy_q     <= 1'b0;
            wr_q      <= bus.req_wr;
            addr_q    <= bus.req_addr;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
`ifdef REG_MST_POLL_EN
            poll_q    <= bus.req_poll & ~bus.req_wr;
            cnt_q     <= '0;
`endif
            if (dec_oor) begin
              state     <= ST_RESP;
              rsp_vld_q <= 1'b1;
              rsp_err_q <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              sel_q     <= dec_sel;
              wr_rd_q   <= bus.req_wr;
              wr_data_q <= bus.req_wr ? bus.req_wdata : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (!wr_q) rdata_q <= dec_rdata;
`ifdef REG_MST_POLL_EN
          cnt_q <= cnt_q + 1'b1;
          if (poll_q && dec_rdata[0]) begin
            // cnt_q counts accesses before this one
            if (cnt_q < CW'(POLL_MAX - 1)) begin
              state <= ST_POLL_GAP;
            end else begin
              state     <= ST_RESP;
              rsp_vld_q <= 1'b1;
              rsp_err_q <= 1'b1;
            end
          end else begin
            state     <= ST_RESP;
            rsp_vld_q <= 1'b1;
          end
`else
          state     <= ST_RESP;
          rsp_vld_q <= 1'b1;
`endif
        end
`ifdef REG_MST_POLL_EN
        ST_POLL_GAP: begin
          state   <= ST_ACCESS;
          sel_q   <= dec_sel;
          wr_rd_q <= 1'b0;
        end
`endif
        ST_RESP: begin
          if (bus.rsp_rdy) begin
            state     <= ST_IDLE;
            rdy_q     <= 1'b1;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_rdy     = rdy_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.reg_wr_sel  = sel_q;
  assign bus.reg_wr_rd   = wr_rd_q;
  assign bus.reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_reg_access_master.sv
// tb/tb_reg_access_master.sv - self-checking bench for reg_access_master against a register-bank model
// Optional feature macro: REG_MST_POLL_EN (enables the poll scenarios)
module tb_reg_access_master;

  localparam int RW = 32;
  localparam int AW = 4;
  localparam int RN = 12;
`ifdef REG_MST_POLL_EN
  localparam int PM = 8;
  int   poll_left = 0;
  logic poll_mode = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [RW-1:0] bank  [RN];
  logic [RW-1:0] model [RN];

  reg_access_master_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .REG_NUM(RN)) bus ();

  reg_access_master #(
    .REG_WIDTH  (RW),
    .ADDR_WIDTH (AW),
`ifdef REG_MST_POLL_EN
    .POLL_MAX   (PM),
`endif
    .REG_NUM    (RN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.reg_rd_bus = '0;
    for (int i = 0; i < RN; i++) bus.reg_rd_bus[i*RW +: RW] = bank[i];
  end

  // register bank: writes land on the strobe edge; in poll mode bit 0 of reg 0 clears after N reads
  always @(posedge clk) begin
    for (int i = 0; i < RN; i++)
      if (bus.reg_wr_sel[i] && bus.reg_wr_rd) bank[i] <= bus.reg_wr_data;
`ifdef REG_MST_POLL_EN
    if (poll_mode && bus.reg_wr_sel[0] && !bus.reg_wr_rd) begin
      poll_left  <= poll_left - 1;
      bank[0][0] <= (poll_left != 1);
    end
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RN-1:0] onehot(input int a);
    logic [RN-1:0] v;
    v = '0;
    if (a >= 0 && a < RN) v[a] = 1'b1;
    return v;
  endfunction

  task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] wdata);
    logic          legal;
    logic [RW-1:0] exp_rdata;
    int            n;
    legal     = (int'(addr) < RN);
    exp_rdata = (legal && !wr) ? model[addr] : '0;
    n = 0;
    while (bus.req_rdy !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("req_rdy_idle", RW'(bus.req_rdy), 1);
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_rdy   = 1'b1;
`ifdef REG_MST_POLL_EN
    bus.req_poll  = (wr || !legal) ? 1'($urandom) : 1'b0;
`endif
    cyc();
    bus.req_vld = 1'b0;
    if (legal) begin
      chk("strobe_sel", RW'(bus.reg_wr_sel), RW'(onehot(int'(addr))));
      chk("strobe_rd", RW'(bus.reg_wr_rd), RW'(wr));
      chk("strobe_data", bus.reg_wr_data, wr ? wdata : '0);
      chk("rsp_early", RW'(bus.rsp_vld), 0);
      cyc();
      if (wr) model[addr] = wdata;
    end
    chk("rsp_sel_off", RW'(bus.reg_wr_sel), 0);
    chk("rsp_vld", RW'(bus.rsp_vld), 1);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("rsp_err", RW'(bus.rsp_err), RW'(!legal));
    chk("req_rdy_busy", RW'(bus.req_rdy), 0);
    cyc();
    chk("rsp_done", RW'(bus.rsp_vld), 0);
    chk("req_rdy_back", RW'(bus.req_rdy), 1);
  endtask

  initial begin
    logic [RW-1:0] wd;
    logic [RW-1:0] held;
    logic          ok;
`ifdef REG_MST_POLL_EN
    int ones_tbl [5] = '{3, 0, 7, 8, 1000};
`endif

    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_rdy   = 1'b1;
`ifdef REG_MST_POLL_EN
    bus.req_poll  = 1'b0;
`endif
    for (int i = 0; i < RN; i++) begin
      bank[i]  = $urandom;
      model[i] = bank[i];
    end

    // reset state
    cyc();
    cyc();
    chk("rst_req_rdy", RW'(bus.req_rdy), 0);
    chk("rst_rsp_vld", RW'(bus.rsp_vld), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", RW'(bus.rsp_err), 0);
    chk("rst_sel", RW'(bus.reg_wr_sel), 0);
    chk("rst_wr_rd", RW'(bus.reg_wr_rd), 0);
    chk("rst_wr_data", bus.reg_wr_data, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_rdy", RW'(bus.req_rdy), 1);

    // directed write, read, illegal address
    xact(1'b1, 4'd2, 32'hA5A50001);
    chk("bank2_written", bank[2], 32'hA5A50001);
    bank[5]  = 32'h0000_0001;
    model[5] = 32'h0000_0001;
    xact(1'b0, 4'd5, 32'hFFFF_FFFF);
    xact(1'b0, 4'd13, 32'h0);
    xact(1'b1, 4'd12, 32'h1234_5678);
    xact(1'b0, 4'd11, 32'h0);
    xact(1'b0, 4'd2, 32'h0);

    // randomized traffic against the bank model
    for (int k = 0; k < 30; k++)
      xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);

    // response backpressure with a new request waiting
    bus.rsp_rdy  = 1'b0;
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = 4'd7;
    cyc();
    wd            = $urandom;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 4'd9;
    bus.req_wdata = wd;
    chk("bp_sel", RW'(bus.reg_wr_sel), RW'(onehot(7)));
    cyc();
    held = bus.rsp_rdata;
    chk("bp_rdata", held, model[7]);
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld_hold", RW'(bus.rsp_vld), 1);
      chk("bp_rdata_hold", bus.rsp_rdata, held);
      chk("bp_rdy_low", RW'(bus.req_rdy), 0);
      chk("bp_no_strobe", RW'(bus.reg_wr_sel), 0);
      cyc();
    end
    bus.rsp_rdy = 1'b1;
    chk("bp_vld_last", RW'(bus.rsp_vld), 1);
    cyc();
    chk("bp_idle_rdy", RW'(bus.req_rdy), 1);
    chk("bp_idle_vld", RW'(bus.rsp_vld), 0);
    chk("bp_idle_sel", RW'(bus.reg_wr_sel), 0);
    cyc();
    bus.req_vld = 1'b0;
    chk("bp_next_sel", RW'(bus.reg_wr_sel), RW'(onehot(9)));
    chk("bp_next_data", bus.reg_wr_data, wd);
    cyc();
    chk("bp_next_rsp", RW'(bus.rsp_vld), 1);
    chk("bp_next_err", RW'(bus.rsp_err), 0);
    model[9] = wd;
    cyc();

    // reset in the middle of an access
    bus.req_vld   = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_wdata = ~model[3];
    cyc();
    bus.req_vld = 1'b0;
    chk("mid_sel_pre", RW'(bus.reg_wr_sel), RW'(onehot(3)));
    rst = 1'b1;
    #1;
    chk("mid_sel_drop", RW'(bus.reg_wr_sel), 0);
    chk("mid_rdy_drop", RW'(bus.req_rdy), 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("mid_rdy_first_edge", RW'(bus.req_rdy), 1);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.rsp_vld !== 1'b0) ok = 1'b0;
      cyc();
    end
    chk("mid_no_rsp", RW'(ok), 1);
    xact(1'b0, 4'd3, 32'h0);
    xact(1'b0, 4'd9, 32'h0);

`ifdef REG_MST_POLL_EN
    // poll reads of register 0: bit 0 stays set for 'ones' reads
    foreach (ones_tbl[t]) begin
      int ones, exp_pulses, pulses, last, n;
      logic exp_err, gap_ok;
      ones       = ones_tbl[t];
      exp_pulses = (ones + 1 < PM) ? ones + 1 : PM;
      exp_err    = (ones >= PM);
      bank[0]    = {16'hABCD, 15'h0, (ones != 0)};
      poll_left  = ones;
      poll_mode  = 1'b1;
      bus.req_vld  = 1'b1;
      bus.req_wr   = 1'b0;
      bus.req_addr = 4'd0;
      bus.req_poll = 1'b1;
      cyc();
      bus.req_vld  = 1'b0;
      bus.req_poll = 1'b0;
      pulses = 0;
      last   = -1;
      gap_ok = 1'b1;
      n      = 0;
      while (bus.rsp_vld !== 1'b1 && n < 40) begin
        if (bus.reg_wr_sel[0]) begin
          if (last >= 0 && n - last != 2) gap_ok = 1'b0;
          last = n;
          pulses++;
        end
        cyc();
        n++;
      end
      chk("poll_rsp_vld", RW'(bus.rsp_vld), 1);
      chk("poll_pulses", RW'(pulses), RW'(exp_pulses));
      chk("poll_gap", RW'(gap_ok), 1);
      chk("poll_err", RW'(bus.rsp_err), RW'(exp_err));
      chk("poll_rdata", bus.rsp_rdata, {16'hABCD, 15'h0, exp_err});
      cyc();
      poll_mode = 1'b0;
      model[0]  = bank[0];
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
